// File: rtl/gesture_pkg.sv
// Shared gesture codes, frame constants and FSM state types
// for the gesture UART receiver.
package gesture_pkg;

  localparam logic [7:0] GEST_NONE          = 8'd0;
  localparam logic [7:0] GEST_ROCK          = 8'd1;
  localparam logic [7:0] GEST_PAPER         = 8'd2;
  localparam logic [7:0] GEST_SCISSORS      = 8'd3;
  localparam logic [7:0] GEST_THUMB         = 8'd4;
  localparam logic [7:0] GEST_INDEX         = 8'd5;
  localparam logic [7:0] GEST_MIDDLE        = 8'd6;
  localparam logic [7:0] GEST_RING          = 8'd7;
  localparam logic [7:0] GEST_PINKY         = 8'd8;
  localparam logic [7:0] GEST_PINKY_PROMISE = 8'd9;
  localparam logic [7:0] GEST_ROCK_SIGN     = 8'd10;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    GOT_SYNC,
    GOT_CODE
  } parse_st_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  function automatic logic code_ok(
    input logic [7:0]  code,
    input logic [7:0]  chk,
    input int unsigned gmax
  );
    return (chk == ~code) && (code != 8'd0)
        && (32'(code) <= gmax);
  endfunction

endpackage

// File: rtl/gesture_if.sv
// Gesture command bus from the UART parser to
// gesture_decoder.
interface gesture_if;
  logic [7:0] gesture;
  logic       gesture_strobe;
  logic       frame_err;
  logic       line_err;

  modport master (
    output gesture,
    output gesture_strobe,
    output frame_err,
    output line_err
  );

  modport slave (
    input gesture,
    input gesture_strobe,
    input frame_err,
    input line_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling,
// one-cycle byte_valid / byte_err pulses.
module uart_rx_byte
  import gesture_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END =
    CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rxs;
  rx_st_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    sh, sh_n;
  logic          armed, armed_n;
  logic          valid_n, err_n;

  assign data = sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      armed      <= 1'b0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      st         <= st_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      sh         <= sh_n;
      armed      <= armed_n;
      byte_valid <= valid_n;
      byte_err   <= err_n;
    end
  end

  // armed stays low until the line is seen idle-high again
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    sh_n    = sh;
    armed_n = armed;
    valid_n = 1'b0;
    err_n   = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!armed)
          armed_n = rxs;
        else if (!rxs)
          st_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          st_n  = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          sh_n  = {rxs, sh[7:1]};
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            st_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          st_n  = RX_IDLE;
          if (rxs) begin
            valid_n = 1'b1;
          end else begin
            err_n   = 1'b1;
            armed_n = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: st_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/gesture_uart_rx.sv
// UART frame parser (SYNC, CODE, CHECK) driving the held
// gesture code and its strobe / error pulses.
module gesture_uart_rx
  import gesture_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned TIMEOUT_BITS = 40,
  parameter int unsigned GEST_MAX     = 10
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rx,
  gesture_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TMO_LIM =
    TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TMO_LIM + 1);
  localparam logic [TW-1:0] TMO_END = TW'(TMO_LIM - 1);

  logic [7:0]    rx_data;
  logic          byte_valid, byte_err;
  parse_st_t     st, st_n;
  logic [7:0]    code, code_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [7:0]    gest, gest_n;
  logic          strobe, strobe_n;
  logic          ferr, ferr_n;
  logic          lerr, lerr_n;
  logic          tmo_run;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  assign bus.gesture        = gest;
  assign bus.gesture_strobe = strobe;
  assign bus.frame_err      = ferr;
  assign bus.line_err       = lerr;

  assign tmo_run = !byte_valid && !byte_err
                && (st != HUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= HUNT;
      code   <= '0;
      tmo    <= '0;
      gest   <= GEST_NONE;
      strobe <= 1'b0;
      ferr   <= 1'b0;
      lerr   <= 1'b0;
    end else begin
      st     <= st_n;
      code   <= code_n;
      tmo    <= tmo_n;
      gest   <= gest_n;
      strobe <= strobe_n;
      ferr   <= ferr_n;
      lerr   <= lerr_n;
    end
  end

  // a received byte always outranks a same-cycle timeout
  always_comb begin
    st_n     = st;
    code_n   = code;
    tmo_n    = tmo;
    gest_n   = gest;
    strobe_n = 1'b0;
    ferr_n   = 1'b0;
    lerr_n   = 1'b0;
    unique case (1'b1)
      byte_err: begin
        lerr_n = 1'b1;
        st_n   = HUNT;
        tmo_n  = '0;
      end
      byte_valid: begin
        tmo_n = '0;
        unique case (st)
          HUNT: begin
            if (rx_data == SYNC_BYTE)
              st_n = GOT_SYNC;
          end
          GOT_SYNC: begin
            code_n = rx_data;
            st_n   = GOT_CODE;
          end
          GOT_CODE: begin
            st_n = HUNT;
            if (code_ok(code, rx_data, GEST_MAX)) begin
              gest_n   = code;
              strobe_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end
          default: st_n = HUNT;
        endcase
      end
      tmo_run: begin
        if (tmo == TMO_END) begin
          ferr_n = 1'b1;
          st_n   = HUNT;
          tmo_n  = '0;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      default: tmo_n = '0;
    endcase
  end

endmodule

// File: tb/tb_gesture_uart_rx.sv
// Directed bench for gesture_uart_rx at 32 clocks per bit.
// Immediate assertions on every checkpoint.
module tb_gesture_uart_rx;
  import gesture_pkg::*;

  localparam int unsigned CLK_HZ = 3_686_400;
  localparam int unsigned BAUD   = 115_200;
  localparam int          CPB    = 32;
  // start edge of CHECK byte to strobe sample:
  // 2 sync + 16 start + 8*32 data + 32 stop + 2 = 308
  localparam int          LAT    = 308;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  gesture_if bus ();

  gesture_uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(40),
    .GEST_MAX    (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_str = 0, n_fe = 0, n_le = 0, n_both = 0;
  int last_str = 0;
  int byte_t0 = 0;
  int s_str, s_fe, s_le;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.gesture_strobe) begin
      n_str    <= n_str + 1;
      last_str <= cyc;
    end
    if (bus.frame_err) n_fe <= n_fe + 1;
    if (bus.line_err)  n_le <= n_le + 1;
    if (int'(bus.gesture_strobe) + int'(bus.frame_err)
        + int'(bus.line_err) > 1)
      n_both <= n_both + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_str = n_str;
    s_fe  = n_fe;
    s_le  = n_le;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    @(negedge clk);
    rx = 1'b0;
    byte_t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] c);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(c, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_gesture", 32'(bus.gesture), 32'h0);
    chk("rst_strobe", 32'(bus.gesture_strobe), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_line_err", 32'(bus.line_err), 32'h0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    snap();
    frame(SYNC_BYTE, GEST_SCISSORS, 8'hFC);
    chk("t1_gesture", 32'(bus.gesture), 32'h03);
    chk("t1_strobes", n_str - s_str, 1);
    chk("t1_latency", last_str - byte_t0, LAT);
    chk("t1_frame_err", n_fe - s_fe, 0);
    chk("t1_line_err", n_le - s_le, 0);

    snap();
    frame(SYNC_BYTE, GEST_PAPER, 8'hFD);
    chk("t2_gesture", 32'(bus.gesture), 32'h02);
    chk("t2_strobes", n_str - s_str, 1);
    snap();
    frame(SYNC_BYTE, 8'h03, 8'h00);
    chk("t2_bad_chk_fe", n_fe - s_fe, 1);
    chk("t2_bad_chk_gest", 32'(bus.gesture), 32'h02);
    chk("t2_bad_chk_str", n_str - s_str, 0);

    snap();
    frame(SYNC_BYTE, 8'h0B, 8'hF4);
    chk("t3_code11_fe", n_fe - s_fe, 1);
    snap();
    frame(SYNC_BYTE, 8'h00, 8'hFF);
    chk("t3_code0_fe", n_fe - s_fe, 1);
    chk("t3_code0_gest", 32'(bus.gesture), 32'h02);
    snap();
    frame(SYNC_BYTE, GEST_ROCK_SIGN, 8'hF5);
    chk("t3_code10_gest", 32'(bus.gesture), 32'h0A);
    chk("t3_code10_str", n_str - s_str, 1);
    chk("t3_code10_fe", n_fe - s_fe, 0);

    snap();
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    chk("t4_line_err", n_le - s_le, 1);
    chk("t4_no_fe", n_fe - s_fe, 0);
    chk("t4_gest_held", 32'(bus.gesture), 32'h0A);
    snap();
    frame(SYNC_BYTE, GEST_ROCK, 8'hFE);
    chk("t4_resync_gest", 32'(bus.gesture), 32'h01);
    chk("t4_resync_str", n_str - s_str, 1);

    snap();
    send_byte(SYNC_BYTE, 1'b1);
    repeat (41 * CPB) @(negedge clk);
    chk("t5_timeout_fe", n_fe - s_fe, 1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFE, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_after_fe", n_fe - s_fe, 1);
    chk("t5_gest", 32'(bus.gesture), 32'h01);
    chk("t5_no_str", n_str - s_str, 0);

    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t5_glitch_pulses",
        (n_str - s_str) + (n_fe - s_fe) + (n_le - s_le), 0);

    send_byte(SYNC_BYTE, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    chk("t6_pre_gest", 32'(bus.gesture), 32'h01);
    reset = 1'b0;
    #1;
    chk("t6_rst_gest", 32'(bus.gesture), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    frame(SYNC_BYTE, GEST_INDEX, 8'hFA);
    chk("t6_gest", 32'(bus.gesture), 32'h05);
    chk("t6_str", n_str - s_str, 1);
    chk("t6_fe", n_fe - s_fe, 0);
    chk("t6_le", n_le - s_le, 0);

    chk("no_overlap", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
